// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: bus bundle for uart_tx_fifo (master = processor side, slave = transmitter).
// Signals: eight/pen/ohel framing, k bit time, load/din write port, clr_ovf,
// tx serial out, txrdy/empty/busy/ovf status, level occupancy.
// brk is present only when UART_TX_BREAK_EN is defined.
interface uart_tx_fifo_if #(parameter int AW = 3);
  logic        eight;
  logic        pen;
  logic        ohel;
  logic [18:0] k;
  logic        load;
  logic [7:0]  din;
  logic        clr_ovf;
`ifdef UART_TX_BREAK_EN
  logic        brk;
`endif
  logic        tx;
  logic        txrdy;
  logic        empty;
  logic        busy;
  logic        ovf;
  logic [AW:0] level;
  modport master(
    output eight, pen, ohel, k, load, din, clr_ovf,
`ifdef UART_TX_BREAK_EN
    output brk,
`endif
    input tx, txrdy, empty, busy, ovf, level
  );
  modport slave(
    input eight, pen, ohel, k, load, din, clr_ovf,
`ifdef UART_TX_BREAK_EN
    input brk,
`endif
    output tx, txrdy, empty, busy, ovf, level
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 11 bit-time frames, LSB first.
// Ports: clk, reset (async active-high), bus (uart_tx_fifo_if.slave).
// Optional macro UART_TX_BREAK_EN adds bus.brk: hold tx low while idle.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic          clk,
  input logic          reset,
  uart_tx_fifo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t        r_state, w_next;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_level;
  logic [10:0]   r_frame;
  logic [3:0]    r_bit;
  logic [18:0]   r_cnt, r_k;
  logic          r_ovf, r_brk, r_rec;
  logic          w_full, w_push, w_pop, w_tc, w_go, w_par;
  logic [7:0]    w_d, w_dm;
  logic [18:0]   w_k;
  assign w_full = r_level == (AW+1)'(DEPTH);
  assign w_push = bus.load && !w_full;
  assign w_pop  = r_state == LOAD;
  assign w_tc   = r_cnt == r_k - 19'd1;
  assign w_k    = bus.k < 19'd2 ? 19'd2 : bus.k;
  assign w_d    = r_mem[r_rd];
  assign w_dm   = bus.eight ? w_d : {1'b0, w_d[6:0]};
  assign w_par  = ^w_dm ^ bus.ohel;
  // r_brk/r_rec: break active, and post-break recovery of one bit time
  assign w_go   = r_level != '0 && !r_brk && !r_rec;
  assign bus.tx    = r_state == SHIFT ? r_frame[r_bit] : !(r_state == IDLE && r_brk);
  assign bus.txrdy = !w_full;
  assign bus.empty = r_level == '0;
  assign bus.busy  = r_state != IDLE;
  assign bus.ovf   = r_ovf;
  assign bus.level = r_level;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_go) w_next = LOAD;
    else if (r_state == LOAD) w_next = SHIFT;
    else if (r_state == SHIFT && w_tc && r_bit == 4'd10) w_next = w_go ? LOAD : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= bus.din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_frame <= '1;
      r_bit   <= '0;
      r_cnt   <= '0;
      r_k     <= 19'd2;
      r_brk   <= 1'b0;
      r_rec   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_ovf   <= (bus.load && w_full) || (r_ovf && !bus.clr_ovf);
`ifdef UART_TX_BREAK_EN
      r_brk <= bus.brk;
`endif
      if (w_pop) begin
        r_frame <= {1'b1, (bus.eight && bus.pen) ? w_par : 1'b1,
                    bus.eight ? w_d[7] : (bus.pen ? w_par : 1'b1), w_d[6:0], 1'b0};
        r_k     <= w_k;
        r_bit   <= '0;
        r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
        r_cnt <= w_tc ? '0 : r_cnt + 19'd1;
        if (w_tc) r_bit <= r_bit + 4'd1;
      end else if (r_brk) begin
        r_rec <= 1'b1;
        r_cnt <= '0;
      end else if (r_rec) begin
        r_cnt <= r_cnt + 19'd1;
        if (r_cnt >= w_k - 19'd1) r_rec <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed vector table plus corner-case sequences for uart_tx_fifo.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  uart_tx_fifo_if #(.AW(3)) bus();
  uart_tx_fifo #(.DEPTH(8), .AW(3)) dut(.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [18:0] k;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [7:0]  din;
    logic [10:0] frame;
  } vec_t;
  vec_t vt[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic clk1();
    @(negedge clk);
  endtask
  task automatic push(input logic [7:0] d);
    bus.din = d;
    bus.load = 1'b1;
    clk1();
    bus.load = 1'b0;
  endtask
  initial begin
    int kk;
    int lv[9];
    logic [10:0] fr[3];
    logic es[$];
    logic ok;
    logic [10:0] bits;
    logic [7:0] b, data;
    logic perr, ferr;
    int nd;
    vt[0] = '{19'd4, 1'b1, 1'b1, 1'b0, 8'hA5, 11'b1_0_1_0100101_0};
    vt[1] = '{19'd3, 1'b0, 1'b1, 1'b1, 8'h41, 11'b1_1_1_1000001_0};
    vt[2] = '{19'd2, 1'b1, 1'b0, 1'b0, 8'h3C, 11'b1_1_0_0111100_0};
    vt[3] = '{19'd1, 1'b0, 1'b0, 1'b1, 8'hFF, 11'b1_1_1_1111111_0};
    vt[4] = '{19'd5, 1'b1, 1'b1, 1'b1, 8'h01, 11'b1_0_0_0000001_0};
    vt[5] = '{19'd0, 1'b0, 1'b1, 1'b0, 8'h80, 11'b1_1_0_0000000_0};
    vt[6] = '{19'd3, 1'b1, 1'b1, 1'b0, 8'hFE, 11'b1_1_1_1111110_0};
    bus.eight = 1'b1; bus.pen = 1'b0; bus.ohel = 1'b0; bus.k = 19'd4;
    bus.load = 1'b0; bus.din = 8'h00; bus.clr_ovf = 1'b0;
`ifdef UART_TX_BREAK_EN
    bus.brk = 1'b0;
`endif
    repeat (3) clk1();
    chk("rst_tx", bus.tx, 1); chk("rst_txrdy", bus.txrdy, 1); chk("rst_empty", bus.empty, 1);
    chk("rst_busy", bus.busy, 0); chk("rst_ovf", bus.ovf, 0); chk("rst_level", bus.level, 0);
    reset = 1'b0;
    clk1();
    for (int v = 0; v < 7; v++) begin
      bus.k = vt[v].k; bus.eight = vt[v].eight; bus.pen = vt[v].pen; bus.ohel = vt[v].ohel;
      kk = vt[v].k < 2 ? 2 : int'(vt[v].k);
      push(vt[v].din);
      chk("level_after_load", bus.level, 1);
      chk("pre_load_tx", bus.tx, 1);
      clk1();
      chk("load_tx", bus.tx, 1); chk("load_busy", bus.busy, 1);
      for (int i = 0; i < 11 * kk; i++) begin
        clk1();
        chk("frame_bit", bus.tx, vt[v].frame[i / kk]);
        if (i == 0) begin
          bus.eight = !bus.eight; bus.pen = !bus.pen; bus.ohel = !bus.ohel; bus.k = 19'd7;
          chk("busy_shift", bus.busy, 1);
        end
      end
      clk1();
      chk("end_busy", bus.busy, 0); chk("end_tx", bus.tx, 1); chk("end_empty", bus.empty, 1);
    end
    lv = '{1, 2, 2, 3, 4, 5, 6, 7, 8};
    bus.k = 19'd1000; bus.eight = 1'b1; bus.pen = 1'b0;
    bus.load = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.din = 8'(i);
      clk1();
      chk("ovf_fill_level", bus.level, lv[i]);
      chk("ovf_fill_txrdy", bus.txrdy, lv[i] != 8);
    end
    chk("ovf_not_yet", bus.ovf, 0);
    clk1();
    bus.load = 1'b0;
    chk("ovf_set", bus.ovf, 1); chk("ovf_level", bus.level, 8);
    bus.clr_ovf = 1'b1;
    clk1();
    chk("ovf_clr", bus.ovf, 0);
    bus.load = 1'b1;
    clk1();
    chk("ovf_set_wins", bus.ovf, 1);
    bus.load = 1'b0;
    clk1();
    bus.clr_ovf = 1'b0;
    chk("ovf_clr2", bus.ovf, 0);
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    chk("flush_level", bus.level, 0);
    clk1();
    bus.k = 19'd2; bus.eight = 1'b1; bus.pen = 1'b0; bus.ohel = 1'b0;
    fr = '{11'b1_1_0_1010101_0, 11'b1_1_0_0001111_0, 11'b1_1_1_1000011_0};
    es.push_back(1'b1);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 22; i++) es.push_back(fr[f][i / 2]);
      es.push_back(1'b1);
    end
    bus.din = 8'h55; bus.load = 1'b1;
    clk1();
    bus.din = 8'h0F;
    clk1();
    chk("b2b_stream", bus.tx, es[0]);
    bus.din = 8'hC3;
    clk1();
    bus.load = 1'b0;
    chk("b2b_stream", bus.tx, es[1]);
    for (int i = 2; i < es.size(); i++) begin
      clk1();
      chk("b2b_stream", bus.tx, es[i]);
    end
    chk("b2b_empty", bus.empty, 1); chk("b2b_busy", bus.busy, 0);
    bus.k = 19'd4; bus.pen = 1'b1;
    bus.din = 8'hA5; bus.load = 1'b1;
    clk1();
    bus.din = 8'h3C;
    clk1();
    bus.load = 1'b0;
    for (int i = 0; i < 22; i++) clk1();
    chk("mid_bit5_tx", bus.tx, 0); chk("mid_level", bus.level, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_tx", bus.tx, 1); chk("mid_rst_level", bus.level, 0); chk("mid_rst_busy", bus.busy, 0);
    #1 reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 80; i++) begin
      clk1();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) ok = 1'b0;
    end
    chk("post_rst_quiet", ok, 1);
    bus.k = 19'd3;
    kk = 3;
    for (int c = 0; c < 8; c++) begin
      bus.eight = c[0]; bus.pen = c[1]; bus.ohel = c[2];
      for (int n = 0; n < 32; n++) begin
        b = 8'($urandom_range(0, 255));
        push(b);
        ok = 1'b0;
        for (int t = 0; t < 10 && !ok; t++) begin
          clk1();
          ok = bus.tx == 1'b0;
        end
        chk("rx_start_seen", ok, 1);
        bits = '0;
        for (int t = 1; t < 11 * kk; t++) begin
          clk1();
          if (t % kk == 1) bits[t / kk] = bus.tx;
        end
        clk1();
        nd = bus.eight ? 8 : 7;
        data = bus.eight ? bits[8:1] : {1'b0, bits[7:1]};
        perr = bus.pen && ((^data ^ bits[nd + 1]) != bus.ohel);
        ferr = bits[nd + 1 + int'(bus.pen)] != 1'b1 || bits[0] != 1'b0;
        chk("rx_data", data, bus.eight ? b : {1'b0, b[6:0]});
        chk("rx_perr_ferr", {perr, ferr}, 0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
